// File: rtl/bot_motion_ctl_if.sv
// bot_motion_ctl_if: Rojobot register-side signals shared between the BOT interface and the motion controller.
interface bot_motion_ctl_if;
  logic       upd_sysregs;
  logic [7:0] Sensors;
  logic [7:0] MotCtl;
  logic       upd_pulse;
  modport master(output upd_sysregs, Sensors, input MotCtl, upd_pulse);
  modport slave(input upd_sysregs, Sensors, output MotCtl, upd_pulse);
endinterface

// File: rtl/bot_motion_ctl.sv
// bot_motion_ctl: game-tick detection, button-to-MotCtl mapping and jump FSM; define BOT_AIR_CONTROL_EN to allow steering while airborne.
module bot_motion_ctl #(
  parameter logic [2:0] SPEED       = 3'd4,
  parameter int         JUMP_HEIGHT = 4,
  parameter int         HOLD_TICKS  = 3
) (
  input  logic             clk,
  input  logic             reset,
  bot_motion_ctl_if.slave  bus,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_jump,
  output logic [3:0]       height,
  output logic             airborne
);
  typedef enum logic [1:0] {GROUND, RISE, HOLD, FALL} state_t;
  localparam logic [3:0] JH  = 4'(JUMP_HEIGHT);
  localparam logic [3:0] HT1 = 4'(HOLD_TICKS - 1);
  state_t     state, state_nx;
  logic       upd_d, jmp_d, jump_pending, pend_nx, tick, jmp_rise;
  logic [3:0] hold_cnt, hold_nx, height_nx;
  logic [7:0] mot, mot_rule;
  assign tick     = bus.upd_sysregs ^ upd_d;
  assign jmp_rise = btn_jump & ~jmp_d;
  assign airborne = state != GROUND;
  assign mot_rule = (btn_right & ~btn_left) ? ((bus.Sensors[4:3] == 2'b00) ? {SPEED, 1'b1, SPEED, 1'b1} : 8'h00)
                  : (btn_left & ~btn_right) ? {SPEED, 1'b0, SPEED, 1'b0} : 8'h00;
`ifdef BOT_AIR_CONTROL_EN
  assign mot = mot_rule;
`else
  assign mot = airborne ? 8'h00 : mot_rule;
`endif
  always_comb begin
    state_nx  = state;
    height_nx = height;
    hold_nx   = hold_cnt;
    pend_nx   = jump_pending | (state == GROUND && jmp_rise);
    if (tick)
      case (state)
        GROUND: if (jump_pending | jmp_rise) begin
          state_nx  = (JH == 4'd1) ? HOLD : RISE;
          height_nx = 4'd1;
          hold_nx   = 4'd0;
          pend_nx   = 1'b0;
        end
        RISE: begin
          height_nx = (height < JH) ? height + 4'd1 : JH;
          if (height_nx == JH) begin
            state_nx = HOLD;
            hold_nx  = 4'd0;
          end
        end
        HOLD: if (hold_cnt >= HT1) state_nx = FALL;
              else hold_nx = hold_cnt + 4'd1;
        FALL: begin
          height_nx = (height > 4'd0) ? height - 4'd1 : 4'd0;
          if (height_nx == 4'd0) state_nx = GROUND;
        end
        default: state_nx = GROUND;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= GROUND;
      height        <= 4'd0;
      hold_cnt      <= 4'd0;
      jump_pending  <= 1'b0;
      upd_d         <= bus.upd_sysregs;
      jmp_d         <= btn_jump;
      bus.MotCtl    <= 8'h00;
      bus.upd_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      height        <= height_nx;
      hold_cnt      <= hold_nx;
      jump_pending  <= pend_nx;
      upd_d         <= bus.upd_sysregs;
      jmp_d         <= btn_jump;
      bus.MotCtl    <= mot;
      bus.upd_pulse <= tick;
    end
  end
endmodule

// File: tb/tb_bot_motion_ctl.sv
// tb_bot_motion_ctl: scoreboard bench; expected jump profile queued per toggle, checked on each upd_pulse.
module tb_bot_motion_ctl;
  localparam int JH = 4;
  localparam int HT = 3;
`ifdef BOT_AIR_CONTROL_EN
  localparam logic [7:0] AIR_MOT = 8'h99;
`else
  localparam logic [7:0] AIR_MOT = 8'h00;
`endif
  logic       clk = 1'b0, reset = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic [3:0] height;
  logic       airborne;
  logic [4:0] exp_q[$];
  int         n_tests = 0, n_fail = 0, jt = 0;
  bit         pend = 1'b0;
  bot_motion_ctl_if bus();
  bot_motion_ctl dut(.clk(clk), .reset(reset), .bus(bus), .btn_left(btn_left), .btn_right(btn_right),
                     .btn_jump(btn_jump), .height(height), .airborne(airborne));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int prof(input int k);
    return (k <= JH) ? k : (k <= JH + HT) ? JH : 2 * JH + HT - k;
  endfunction
  task automatic toggle();
    bus.upd_sysregs = ~bus.upd_sysregs;
    if (jt > 0) begin
      jt++;
      if (prof(jt) <= 0) jt = 0;
    end else if (pend) begin
      jt   = 1;
      pend = 1'b0;
    end
    exp_q.push_back({jt != 0, 4'(jt != 0 ? prof(jt) : 0)});
  endtask
  task automatic jump_on();
    btn_jump = 1'b1;
    if (jt == 0) pend = 1'b1;
  endtask
  task automatic tick(input int gap);
    toggle();
    repeat (gap) @(negedge clk);
  endtask
  always @(negedge clk)
    if (!reset && bus.upd_pulse) begin
      if (exp_q.size() == 0) chk("spurious_pulse", 8'd1, 8'd0);
      else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        chk("height", {4'd0, height}, {4'd0, e[3:0]});
        chk("airborne", {7'd0, airborne}, {7'd0, e[4]});
      end
    end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.upd_sysregs = 1'b1;
    bus.Sensors = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_mot", bus.MotCtl, 8'h00);
    chk("rst_height", {4'd0, height}, 8'd0);
    chk("rst_airborne", {7'd0, airborne}, 8'd0);
    repeat (3) begin
      @(negedge clk);
      chk("no_pulse_after_reset", {7'd0, bus.upd_pulse}, 8'd0);
    end
    toggle();
    @(negedge clk) chk("pulse_latency", {7'd0, bus.upd_pulse}, 8'd1);
    @(negedge clk) chk("pulse_once", {7'd0, bus.upd_pulse}, 8'd0);
    btn_right = 1'b1;
    @(negedge clk) chk("mot_right", bus.MotCtl, 8'h99);
    bus.Sensors = 8'h10;
    @(negedge clk) chk("mot_right_prox4", bus.MotCtl, 8'h00);
    bus.Sensors = 8'h08;
    @(negedge clk) chk("mot_right_prox3", bus.MotCtl, 8'h00);
    bus.Sensors = 8'h00; btn_right = 1'b0; btn_left = 1'b1;
    @(negedge clk) chk("mot_left", bus.MotCtl, 8'h88);
    btn_right = 1'b1;
    @(negedge clk) chk("mot_both", bus.MotCtl, 8'h00);
    btn_left = 1'b0;
    @(negedge clk) chk("mot_right_again", bus.MotCtl, 8'h99);
    // pending launch, full profile, right held throughout
    jump_on();
    @(negedge clk) btn_jump = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      toggle();
      @(negedge clk);
      if (k >= 2 && k <= 10) chk("mot_airborne", bus.MotCtl, AIR_MOT);
      if (k == 11) begin
        chk("mot_landing_edge", bus.MotCtl, AIR_MOT);
        @(negedge clk) chk("mot_after_landing", bus.MotCtl, 8'h99);
      end
      repeat (18) @(negedge clk);
    end
    btn_right = 1'b0;
    tick(20);
    // same-cycle launch, back-to-back toggles, re-press during HOLD ignored
    jump_on();
    toggle();
    @(negedge clk) btn_jump = 1'b0;
    repeat (19) @(negedge clk);
    for (int k = 2; k <= 11; k++) begin
      if (k == 6) begin
        jump_on();
        @(negedge clk) btn_jump = 1'b0;
      end
      tick(k == 2 ? 1 : 20);
    end
    repeat (3) tick(20);
    // reset mid-fall at height 3
    jump_on();
    toggle();
    @(negedge clk) btn_jump = 1'b0;
    repeat (19) @(negedge clk);
    for (int k = 2; k <= 8; k++) tick(20);
    chk("pre_reset_height", {4'd0, height}, 8'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_height", {4'd0, height}, 8'd0);
    chk("reset_airborne", {7'd0, airborne}, 8'd0);
    jt = 0; pend = 1'b0;
    reset = 1'b0;
    jump_on();
    @(negedge clk) btn_jump = 1'b0;
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    pend = 1'b0;
    repeat (3) tick(20);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bot_motion_ctl.md
# bot_motion_ctl

Sidescroller motion controller that sits directly downstream of the Rojobot register interface. It edge-detects the `upd_sysregs` toggle flag to derive a once-per-update game tick. It converts debounced player buttons into the 8-bit `MotCtl` motor command that is fed back into the BOT. It also runs the jump state machine that produces the airborne height offset used by the video/icon logic.

## Interface
Parameters:
- `SPEED`, default 3'd4: motor speed code placed in both `lm_spd` and `rm_spd` fields.
- `JUMP_HEIGHT`, default 4: peak height in rows, range 1..15.
- `HOLD_TICKS`, default 3: ticks spent at peak, range 1..15.

Ports:
- `clk`  in  1: system clock. One clock; reset is synchronous and active-high.
- `reset`  in  1: synchronous, active-high reset.
- `upd_sysregs`  in  1: toggle flag from the BOT interface; each toggle is one game tick.
- `Sensors`  in  8: BOT sensor register; bits [4:3] are right/left proximity.
- `btn_left`, `btn_right`, `btn_jump`  in  1 each: debounced, level-sensitive buttons.
- `MotCtl`  out  8: motor command `{lm_spd[2:0], lm_dir, rm_spd[2:0], rm_dir}`.
- `upd_pulse`  out  1: one-cycle pulse per `upd_sysregs` toggle.
- `height`  out  4: current jump height in rows above `LocY`.
- `airborne`  out  1: high in any state other than GROUND.

## Operation
- Tick detection:
  - `upd_d` registers `upd_sysregs`; `tick = upd_sysregs ^ upd_d`.
  - `upd_pulse <= tick`.
  - Either toggle direction counts as a tick.
- Jump edge detection:
  - `jmp_d` registers `btn_jump`; `jmp_rise = btn_jump & ~jmp_d`.
  - In GROUND, `jmp_rise` sets `jump_pending`.
  - In all other states, `jmp_rise` is ignored and not latched.
- Motor command (registered every cycle, not only on ticks):
  - right only, and `Sensors[4:3] == 0` -> `{SPEED,1,SPEED,1}` (8'h99 at default).
  - right only, with proximity set -> 8'h00.
  - left only -> `{SPEED,0,SPEED,0}` (8'h88).
  - both or neither -> 8'h00.
- Jump FSM. States GROUND, RISE, HOLD, FALL; all transitions and counts happen only on cycles where `tick=1`.
  - GROUND: if `jump_pending`, or `jmp_rise` in the same cycle, go to RISE, clear `jump_pending`, and set `height <= 1`.
  - RISE: `height++`. When `height` reaches `JUMP_HEIGHT`, go to HOLD with `hold_cnt <= 0`. If `JUMP_HEIGHT == 1`, the GROUND->RISE tick goes straight to HOLD.
  - HOLD: `hold_cnt++`. When `hold_cnt` reaches `HOLD_TICKS-1`, go to FALL.
  - FALL: `height--`. When `height` becomes 0, go to GROUND.
- Arithmetic:
  - `height` never wraps; it is saturated to 0..`JUMP_HEIGHT`.
  - `hold_cnt` is 4 bits.

## Timing
- Reset values: `MotCtl=8'h00`, `upd_pulse=0`, `height=0`, `airborne=0`, state GROUND, `jump_pending=0`, `jmp_d=btn_jump`.
- During reset, `upd_d` loads `upd_sysregs`, so no spurious tick occurs after reset.
- Latencies:
  - `upd_sysregs` toggle sampled at edge N -> `upd_pulse`, `height` and state all update at edge N+1 (1 cycle).
  - Button change to `MotCtl`: 1 cycle.
- Back-to-back toggles on consecutive cycles produce two consecutive ticks; each is honoured.
- Reset asserted mid-jump: the next edge returns to GROUND with `height=0`. A pending jump is discarded.
- Full jump duration: `2*JUMP_HEIGHT + HOLD_TICKS` ticks from the launch tick to the tick on which `airborne` drops. That is 11 ticks at the defaults.

## Configuration
- `BOT_AIR_CONTROL_EN` defined: the `MotCtl` rules apply in every FSM state.
- Not defined: `MotCtl` is forced to 8'h00 while `airborne=1`. Normal rules resume on the cycle after returning to GROUND.

## Test plan
- Reset release with `upd_sysregs=1` held -> `upd_pulse` stays 0 and `MotCtl`=8'h00. A later 1->0 toggle gives exactly one `upd_pulse`, 1 cycle later.
- `btn_right=1` with `Sensors`=8'h00 -> `MotCtl`=8'h99 after 1 cycle. Setting `Sensors[4]` -> 8'h00. `btn_left` alone -> 8'h88. Both pressed -> 8'h00.
- `btn_jump` pulse, then toggles on every 20th cycle, defaults -> `height` sequence 1,2,3,4,4,4,4,3,2,1,0. `airborne` high for exactly 10 ticks.
- `jmp_rise` on the same cycle as a tick in GROUND -> `height=1` on the next cycle. A second jump press during HOLD -> no second jump after landing.
- `reset` asserted while `height=3` in FALL -> `height=0`, `airborne=0` on the next edge. No further ticks alter state until a new press.
- Without `BOT_AIR_CONTROL_EN`, `btn_right` held through a jump -> `MotCtl`=8'h00 while airborne, and 8'h99 one cycle after landing. With the macro defined -> 8'h99 throughout.
